// File: rtl/md_unit.sv
// ---------------------------------------------------------------------------
// md_unit -- multiply/divide execution unit with architectural HI/LO.
//
// Lives in the E stage of the five-stage MIPS pipeline. mult/multu/div/divu
// are accepted in IDLE, their full 64-bit result is computed from the
// operands present on the start edge and parked, and HI/LO are only
// updated once the fixed busy window has elapsed. mthi/mtlo write straight
// into HI/LO while idle.
//
// Ports:
//   clk       rising-edge clock
//   reset_n   asynchronous active-low reset
//   md_s      start strobe for mult/multu/div/divu
//   md_c      op: 0 multu, 1 mult, 2 divu, 3 div, 4 mthi, 5 mtlo, else nop
//   m_md      read select: 0 HI, 1 LO
//   rs_val    rs operand (multiplicand / dividend / mt data)
//   rt_val    rt operand (multiplier / divisor)
//   hilo_out  m_md ? LO : HI
//   busy      high while an operation is in flight
//   md_stall  busy, or a multiply/divide being started this cycle
// ---------------------------------------------------------------------------
module md_unit #(
  parameter int MULT_LAT = 5,
  parameter int DIV_LAT  = 10
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        md_s,
  input  logic [3:0]  md_c,
  input  logic        m_md,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  output logic [31:0] hilo_out,
  output logic        busy,
  output logic        md_stall
);

  localparam int MAX_LAT = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
  localparam int CNT_W   = $clog2(MAX_LAT + 1);
  localparam logic [CNT_W-1:0] MULT_CNT = CNT_W'(MULT_LAT);
  localparam logic [CNT_W-1:0] DIV_CNT  = CNT_W'(DIV_LAT);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [63:0]      res_reg, res_next;
  logic [31:0]      hi_reg, hi_next;
  logic [31:0]      lo_reg, lo_next;

  // md_c 0..3 are the long-running ops
  logic is_md_op;
  logic start;
  assign is_md_op = (md_c[3:2] == 2'b00);
  assign start    = md_s & is_md_op;

  // ---------------- multiply ----------------
  // Widening both operands to 64 bits (zero- or sign-extended) makes the low
  // 64 bits of the product the exact unsigned or signed result.
  logic [63:0] prod_u;
  logic [63:0] prod_s;
  assign prod_u = {32'd0, rs_val} * {32'd0, rt_val};
  assign prod_s = {{32{rs_val[31]}}, rs_val} * {{32{rt_val[31]}}, rt_val};

  // ---------------- divide ----------------
  // Signed division is done on magnitudes and the signs are reapplied:
  // quotient negative when operand signs differ, remainder follows the
  // dividend. 0x80000000 / -1 falls out naturally: |a|=0x80000000, q
  // negates to itself and r=0.
  logic        div_signed;
  logic        dvd_neg;
  logic        dvs_neg;
  logic [31:0] dvd_mag;
  logic [31:0] dvs_mag;
  logic [31:0] quo_mag;
  logic [31:0] rem_mag;
  logic [31:0] quo;
  logic [31:0] rem;
  logic [63:0] div_res;

  assign div_signed = md_c[0];
  assign dvd_neg    = div_signed & rs_val[31];
  assign dvs_neg    = div_signed & rt_val[31];
  assign dvd_mag    = dvd_neg ? (32'd0 - rs_val) : rs_val;
  assign dvs_mag    = dvs_neg ? (32'd0 - rt_val) : rt_val;
  assign quo_mag    = dvd_mag / dvs_mag;
  assign rem_mag    = dvd_mag % dvs_mag;
  assign quo        = (dvd_neg ^ dvs_neg) ? (32'd0 - quo_mag) : quo_mag;
  assign rem        = dvd_neg ? (32'd0 - rem_mag) : rem_mag;

  // Divide by zero: LO all ones, HI keeps the dividend, signed or not.
  assign div_res = (rt_val == 32'd0) ? {rs_val, 32'hFFFF_FFFF} : {rem, quo};

  logic [63:0] op_result;
  always_comb begin
    op_result = div_res;
    case (md_c[1:0])
      2'd0:    op_result = prod_u;
      2'd1:    op_result = prod_s;
      default: op_result = div_res;
    endcase
  end

  // ---------------- control ----------------
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    res_next   = res_reg;
    hi_next    = hi_reg;
    lo_next    = lo_reg;
    case (state_reg)
      IDLE: begin
        if (start) begin
          state_next = RUN;
          res_next   = op_result;
          cnt_next   = md_c[1] ? DIV_CNT : MULT_CNT;
        end else if (md_c == 4'd4) begin
          hi_next = rs_val;
        end else if (md_c == 4'd5) begin
          lo_next = rs_val;
        end
      end
      RUN: begin
        // New starts and mthi/mtlo are deliberately ignored here.
        cnt_next = cnt_reg - CNT_ONE;
        if (cnt_reg == CNT_ONE) begin
          hi_next    = res_reg[63:32];
          lo_next    = res_reg[31:0];
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      res_reg   <= '0;
      hi_reg    <= '0;
      lo_reg    <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      res_reg   <= res_next;
      hi_reg    <= hi_next;
      lo_reg    <= lo_next;
    end
  end

  assign busy     = (state_reg == RUN);
  assign md_stall = busy | start;
  assign hilo_out = m_md ? lo_reg : hi_reg;

endmodule

// File: tb/tb_md_unit.sv
// ---------------------------------------------------------------------------
// tb_md_unit -- self-checking bench for md_unit.
//
// The reference keeps HI/LO, the pending 64-bit result and the absolute
// cycle number at which the running operation finishes; arithmetic uses
// native 64-bit integer math. A single compare process checks busy,
// md_stall and hilo_out against it every cycle, plus literal expectations
// posted by the directed sequences and probes taken during reset pulses.
// ---------------------------------------------------------------------------
module tb_md_unit;

  localparam int MULT_LAT = 5;
  localparam int DIV_LAT  = 10;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        md_s;
  logic [3:0]  md_c;
  logic        m_md;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic [31:0] hilo_out;
  logic        busy;
  logic        md_stall;

  md_unit #(
    .MULT_LAT(MULT_LAT),
    .DIV_LAT (DIV_LAT)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .md_s    (md_s),
    .md_c    (md_c),
    .m_md    (m_md),
    .rs_val  (rs_val),
    .rt_val  (rt_val),
    .hilo_out(hilo_out),
    .busy    (busy),
    .md_stall(md_stall)
  );

  always #10 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // reference state
  logic [31:0] m_hi;
  logic [31:0] m_lo;
  logic [63:0] m_pend;
  longint      cyc;
  longint      done_at;
  bit          chk_en;

  // literal expectations posted by the stimulus for the current cycle
  bit          lit_bv;
  logic        lit_bexp;
  string       lit_bname;
  bit          lit_hv;
  logic [31:0] lit_hexp;
  string       lit_hname;
  logic        rst_probe;

  function automatic logic [63:0] ref_result(input logic [3:0] op,
                                             input logic [31:0] a,
                                             input logic [31:0] b);
    longint      sa, sb, sq, sr;
    logic [63:0] ua, ub, uq, ur;
    logic [63:0] r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    r  = '0;
    if (op[1:0] == 2'd0) begin
      r = ua * ub;
    end else if (op[1:0] == 2'd1) begin
      r = 64'(sa * sb);
    end else if (b == 32'd0) begin
      r = {a, 32'hFFFF_FFFF};
    end else if (op[0]) begin
      sq = sa / sb;
      sr = sa % sb;
      r  = {sr[31:0], sq[31:0]};
    end else begin
      uq = ua / ub;
      ur = ua % ub;
      r  = {ur[31:0], uq[31:0]};
    end
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
    end
  endtask

  // The one compare process.
  always @(negedge clk or posedge rst_probe) begin
    if (rst_probe) begin
      check("reset_busy", {31'd0, busy}, 32'd0);
      check("reset_hilo", hilo_out, 32'd0);
    end else if (chk_en && reset_n) begin
      check("busy", {31'd0, busy}, {31'd0, (cyc <= done_at)});
      check("md_stall", {31'd0, md_stall},
            {31'd0, ((cyc <= done_at) || (md_s && (md_c < 4'd4)))});
      check("hilo_out", hilo_out, m_md ? m_lo : m_hi);
      if (lit_bv) check(lit_bname, {31'd0, busy}, {31'd0, lit_bexp});
      if (lit_hv) check(lit_hname, hilo_out, lit_hexp);
    end
  end

  // Reference update for the clock edge that ends the current cycle.
  task automatic model_edge();
    if (cyc <= done_at) begin
      if (cyc == done_at) begin
        m_hi = m_pend[63:32];
        m_lo = m_pend[31:0];
      end
    end else if (md_s && (md_c < 4'd4)) begin
      m_pend  = ref_result(md_c, rs_val, rt_val);
      done_at = cyc + ((md_c < 4'd2) ? MULT_LAT : DIV_LAT);
    end else if (md_c == 4'd4) begin
      m_hi = rs_val;
    end else if (md_c == 4'd5) begin
      m_lo = rs_val;
    end
    cyc++;
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    lit_bv = 1'b0;
    lit_hv = 1'b0;
  endtask

  task automatic drive(input logic s, input logic [3:0] c, input logic mm,
                       input logic [31:0] a, input logic [31:0] b);
    md_s   = s;
    md_c   = c;
    m_md   = mm;
    rs_val = a;
    rt_val = b;
  endtask

  // Nop with garbage operands: operands must only matter at the start edge.
  task automatic drive_idle(input logic mm);
    drive(1'b0, 4'hF, mm, $urandom, $urandom);
  endtask

  task automatic exp_busy(input string nm, input logic b);
    lit_bv = 1'b1; lit_bexp = b; lit_bname = nm;
  endtask

  task automatic exp_hilo(input string nm, input logic [31:0] v);
    lit_hv = 1'b1; lit_hexp = v; lit_hname = nm;
  endtask

  // Called just after an active edge; the whole pulse stays within the cycle.
  task automatic pulse_reset();
    reset_n = 1'b0;
    m_md    = 1'b0;
    m_hi    = '0;
    m_lo    = '0;
    done_at = -1;
    #1 rst_probe = 1'b1;
    #1 rst_probe = 1'b0; m_md = 1'b1;
    #1 rst_probe = 1'b1;
    #1 rst_probe = 1'b0;
    #1 reset_n = 1'b1;
  endtask

  task automatic run_op(input string nm, input logic [3:0] c, input logic [31:0] a,
                        input logic [31:0] b, input int lat,
                        input logic [31:0] eh, input logic [31:0] el);
    drive(1'b1, c, 1'b0, a, b);
    tick();
    drive_idle(1'b0);
    for (int i = 0; i < lat; i++) begin
      exp_busy({nm, "_busy"}, 1'b1);
      tick();
    end
    exp_busy({nm, "_idle"}, 1'b0);
    exp_hilo({nm, "_hi"}, eh);
    tick();
    drive_idle(1'b1);
    exp_hilo({nm, "_lo"}, el);
    tick();
  endtask

  function automatic logic [31:0] pick();
    logic [31:0] v;
    case ($urandom_range(0, 7))
      0: v = 32'd0;
      1: v = 32'hFFFF_FFFF;
      2: v = 32'h8000_0000;
      3: v = 32'($urandom_range(0, 20));
      default: v = $urandom;
    endcase
    return v;
  endfunction

  initial begin
    reset_n   = 1'b1;
    rst_probe = 1'b0;
    chk_en    = 1'b0;
    lit_bv    = 1'b0;
    lit_hv    = 1'b0;
    m_hi      = '0;
    m_lo      = '0;
    m_pend    = '0;
    cyc       = 0;
    done_at   = -1;
    drive(1'b0, 4'hF, 1'b0, 32'd0, 32'd0);

    // Reset state, probed while reset_n is held low.
    #1 reset_n = 1'b0;
    #1 rst_probe = 1'b1;
    #1 rst_probe = 1'b0; m_md = 1'b1;
    #1 rst_probe = 1'b1;
    #1 rst_probe = 1'b0;
    #10 reset_n = 1'b1;
    chk_en = 1'b1;
    tick();

    // Arithmetic and latency.
    run_op("mult",     4'd1, 32'hFFFF_FFFF, 32'd2,         MULT_LAT, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
    run_op("multu",    4'd0, 32'hFFFF_FFFF, 32'd2,         MULT_LAT, 32'h0000_0001, 32'hFFFF_FFFE);
    run_op("div",      4'd3, 32'hFFFF_FFF9, 32'd2,         DIV_LAT,  32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op("divu_z",   4'd2, 32'd7,         32'd0,         DIV_LAT,  32'h0000_0007, 32'hFFFF_FFFF);
    run_op("div_ovf",  4'd3, 32'h8000_0000, 32'hFFFF_FFFF, DIV_LAT,  32'h0000_0000, 32'h8000_0000);

    // mthi in IDLE.
    drive(1'b0, 4'd4, 1'b0, 32'h0000_1234, 32'd0);
    tick();
    drive_idle(1'b0);
    exp_hilo("mthi", 32'h0000_1234);
    tick();

    // mtlo during a busy mult is dropped.
    drive(1'b1, 4'd1, 1'b1, 32'd3, 32'd5);
    tick();
    drive(1'b0, 4'd5, 1'b1, 32'h0000_0055, 32'd0);
    tick();
    drive_idle(1'b1);
    repeat (4) tick();
    exp_busy("mtlo_ign_idle", 1'b0);
    exp_hilo("mtlo_ign_lo", 32'd15);
    tick();

    // div start during a busy mult is dropped; back-to-back mult in LAT+1.
    drive(1'b1, 4'd1, 1'b1, 32'd6, 32'd7);
    tick();
    drive(1'b1, 4'd3, 1'b1, 32'd100, 32'd3);
    tick();
    drive_idle(1'b1);
    repeat (4) tick();
    drive(1'b1, 4'd0, 1'b1, 32'd2, 32'd3);
    exp_busy("b2b_idle", 1'b0);
    exp_hilo("div_ign_lo", 32'd42);
    tick();
    drive_idle(1'b1);
    exp_busy("b2b_busy", 1'b1);
    tick();
    repeat (4) tick();
    exp_busy("b2b_done", 1'b0);
    exp_hilo("b2b_lo", 32'd6);
    tick();

    // Reset in busy cycle 3 of a mult: nothing is ever committed.
    drive(1'b1, 4'd1, 1'b1, 32'd9, 32'd9);
    tick();
    drive_idle(1'b1);
    tick();
    tick();
    pulse_reset();
    drive_idle(1'b1);
    repeat (MULT_LAT) tick();
    exp_busy("abort_busy", 1'b0);
    exp_hilo("abort_lo", 32'd0);
    tick();

    // Randomised traffic against the reference.
    for (int n = 0; n < 3000; n++) begin
      md_s = ($urandom_range(0, 3) == 0);
      md_c = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(4, 15))
                                         : 4'($urandom_range(0, 3));
      m_md   = 1'($urandom_range(0, 1));
      rs_val = pick();
      rt_val = pick();
      if ($urandom_range(0, 399) == 0) pulse_reset();
      tick();
    end

    drive_idle(1'b0);
    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
